// File: rtl/axi_write_slave.sv
// ---------------------------------------------------------------------------
// axi_write_slave
//
// AXI4 write subordinate for the AXI-to-I2C bridge. Accepts one AW request,
// sinks the W burst up to WLAST, forwards each accepted beat (with its
// computed address) over a valid/ready stream toward the I2C command FIFO,
// and returns one B response per burst. One transaction in flight at a time.
//
// Ports:
//   ACLK, ARESETn           clock (rising edge), synchronous active-low reset
//   AWVALID/AWREADY         write request handshake
//   AWADDR, AWSIZE, AWBURST start address, log2 bytes per beat, burst type
//   WVALID/WREADY           write data handshake
//   WDATA, WLAST            beat data, final beat marker
//   BVALID/BREADY, BRESP    write response handshake and code
//   out_valid/out_ready     forwarded beat handshake toward the I2C side
//   out_addr, out_data      address and data of the forwarded beat
//   out_last                forwarded beat carries WLAST
// ---------------------------------------------------------------------------
module axi_write_slave #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    SIZE_WIDTH  = 3,
    parameter int                    BURST_WIDTH = 2,
    parameter int                    RESP_WIDTH  = 2,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LO     = 8'h80,
    parameter logic [ADDR_WIDTH-1:0] ADDR_HI     = 8'hBF,
    parameter int                    MAX_BEATS   = 16
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [ADDR_WIDTH-1:0]  AWADDR,
    input  logic [SIZE_WIDTH-1:0]  AWSIZE,
    input  logic [BURST_WIDTH-1:0] AWBURST,
    input  logic                   WVALID,
    output logic                   WREADY,
    input  logic [DATA_WIDTH-1:0]  WDATA,
    input  logic                   WLAST,
    output logic                   BVALID,
    input  logic                   BREADY,
    output logic [RESP_WIDTH-1:0]  BRESP,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last
);

    localparam logic [RESP_WIDTH-1:0]  RESP_OKAY    = RESP_WIDTH'(0);
    localparam logic [RESP_WIDTH-1:0]  RESP_SLVERR  = RESP_WIDTH'(2);
    localparam logic [RESP_WIDTH-1:0]  RESP_DECERR  = RESP_WIDTH'(3);
    localparam logic [BURST_WIDTH-1:0] BURST_FIXED  = BURST_WIDTH'(0);
    localparam logic [BURST_WIDTH-1:0] BURST_INCR   = BURST_WIDTH'(1);
    localparam logic [31:0]            BEAT_BYTES   = 32'(DATA_WIDTH / 8);
    localparam logic [7:0]             MAX_CNT      = 8'(MAX_BEATS);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        DATA = 3'b010,
        RESP = 3'b100
    } state_t;

    state_t                 state;
    logic                   awready_q;
    logic                   bvalid_q;
    logic [RESP_WIDTH-1:0]  bresp_q;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [SIZE_WIDTH-1:0]  cur_size;
    logic [BURST_WIDTH-1:0] cur_burst;
    logic [RESP_WIDTH-1:0]  cur_err;
    logic                   ovf_flag;
    logic [7:0]             beat_cnt;

    logic [RESP_WIDTH-1:0]  aw_err;
    logic                   in_data;
    logic                   at_max;
    logic                   drain;
    logic                   aw_hs;
    logic                   w_hs;

    // Decode of the incoming request; address window has priority over
    // size/burst checks.
    always_comb begin
        aw_err = RESP_OKAY;
        if ((AWADDR < ADDR_LO) || (AWADDR > ADDR_HI)) begin
            aw_err = RESP_DECERR;
        end else if (((32'd1 << AWSIZE) > BEAT_BYTES) ||
                     ((AWBURST != BURST_FIXED) && (AWBURST != BURST_INCR))) begin
            aw_err = RESP_SLVERR;
        end
    end

    // A beat is drained instead of forwarded when the burst was rejected at
    // decode, or once MAX_BEATS beats have already been accepted.
    assign in_data = (state == DATA);
    assign at_max  = (beat_cnt == MAX_CNT);
    assign drain   = (cur_err != RESP_OKAY) || ovf_flag || at_max;

    assign WREADY    = in_data && (drain || out_ready);
    assign out_valid = in_data && !drain && WVALID;
    assign out_last  = in_data && !drain && WLAST;
    assign out_addr  = cur_addr;
    assign out_data  = WDATA;

    assign AWREADY = awready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;

    assign aw_hs = (state == IDLE) && AWVALID && awready_q;
    assign w_hs  = in_data && WVALID && WREADY;

    // AWREADY is low in the first IDLE cycle after reset or after a B
    // handshake, which gives the minimum one-cycle gap between bursts.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= IDLE;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            cur_addr  <= '0;
            cur_size  <= '0;
            cur_burst <= BURST_FIXED;
            cur_err   <= RESP_OKAY;
            ovf_flag  <= 1'b0;
            beat_cnt  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        awready_q <= 1'b0;
                        cur_addr  <= AWADDR;
                        cur_size  <= AWSIZE;
                        cur_burst <= AWBURST;
                        cur_err   <= aw_err;
                        ovf_flag  <= 1'b0;
                        beat_cnt  <= 8'd0;
                        state     <= DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end

                DATA: begin
                    if (w_hs) begin
                        if (beat_cnt != 8'hFF) begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                        if (at_max) begin
                            ovf_flag <= 1'b1;
                        end
                        if (cur_burst == BURST_INCR) begin
                            cur_addr <= cur_addr + (ADDR_WIDTH'(1) << cur_size);
                        end
                        if (WLAST) begin
                            bvalid_q <= 1'b1;
                            if (cur_err != RESP_OKAY) begin
                                bresp_q <= cur_err;
                            end else if (ovf_flag || at_max) begin
                                bresp_q <= RESP_SLVERR;
                            end else begin
                                bresp_q <= RESP_OKAY;
                            end
                            state <= RESP;
                        end
                    end
                end

                RESP: begin
                    if (BREADY) begin
                        bvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    awready_q <= 1'b0;
                    bvalid_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_write_slave
//
// Self-checking bench for axi_write_slave. A table of burst records (request
// fields, backpressure window, BREADY delay, expected response and expected
// forwarded-beat count) is driven through one master/monitor task; a few
// hand-written sequences cover reset behaviour and stray W traffic in IDLE.
// Inputs change on the falling edge, outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_axi_write_slave;

    localparam int MAX_BEATS = 16;

    logic        ACLK;
    logic        ARESETn;
    logic        AWVALID;
    logic        AWREADY;
    logic [7:0]  AWADDR;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        WVALID;
    logic        WREADY;
    logic [31:0] WDATA;
    logic        WLAST;
    logic        BVALID;
    logic        BREADY;
    logic [1:0]  BRESP;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;

    int checks = 0;
    int errors = 0;

    axi_write_slave #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .SIZE_WIDTH (3),
        .BURST_WIDTH(2),
        .RESP_WIDTH (2),
        .ADDR_LO    (8'h80),
        .ADDR_HI    (8'hBF),
        .MAX_BEATS  (MAX_BEATS)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .AWADDR   (AWADDR),
        .AWSIZE   (AWSIZE),
        .AWBURST  (AWBURST),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .WDATA    (WDATA),
        .WLAST    (WLAST),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .BRESP    (BRESP),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .out_data (out_data),
        .out_last (out_last)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // One burst record: request, stimulus shaping, hand-computed results.
    typedef struct {
        logic [7:0]  addr;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          beats;
        logic [31:0] dataBase;
        int          bpStart;
        int          bpLen;
        int          breadyDelay;
        logic [1:0]  expResp;
        int          expFwd;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [31:0] beatData(input logic [31:0] base, input int k);
        return base + 32'(k) * 32'h0101_0101;
    endfunction

    function automatic logic [7:0] beatAddr(input vec_t v, input int k);
        logic [7:0] step;
        step = 8'd1 << v.size;
        if (v.burst == 2'b01) begin
            return v.addr + 8'(k) * step;
        end
        return v.addr;
    endfunction

    // Drives one full burst (AW, W beats, B) and checks every forwarded beat,
    // the W/out handshake levels, the response and the AWREADY gap afterwards.
    // Entered and left on a falling edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        int         guard;
        int         cyc;
        int         accepted;
        int         fwd;
        logic       decodeErr;
        logic       drainNow;
        logic [1:0] respSeen;

        decodeErr = (v.expFwd == 0);

        AWVALID = 1'b1;
        AWADDR  = v.addr;
        AWSIZE  = v.size;
        AWBURST = v.burst;
        guard   = 0;
        while (AWREADY !== 1'b1 && guard < 20) begin
            @(negedge ACLK);
            guard++;
        end
        if (guard >= 20) begin
            reportTimeout($sformatf("v%0d aw_handshake", idx));
            AWVALID = 1'b0;
            return;
        end
        @(negedge ACLK);
        AWVALID = 1'b0;
        checkOutput($sformatf("v%0d awready_after_hs", idx), 64'(AWREADY), 64'(1'b0));

        accepted = 0;
        fwd      = 0;
        cyc      = 0;
        while (accepted < v.beats && cyc < 300) begin
            WVALID    = 1'b1;
            WDATA     = beatData(v.dataBase, accepted);
            WLAST     = (accepted == v.beats - 1);
            out_ready = !((cyc >= v.bpStart) && (cyc < v.bpStart + v.bpLen));
            #1;
            drainNow = decodeErr || (accepted >= MAX_BEATS);
            checkOutput($sformatf("v%0d wready c%0d", idx, cyc), 64'(WREADY),
                        64'(drainNow ? 1'b1 : out_ready));
            checkOutput($sformatf("v%0d out_valid c%0d", idx, cyc), 64'(out_valid),
                        64'(!drainNow));
            if (out_valid && out_ready) begin
                checkOutput($sformatf("v%0d out_addr b%0d", idx, accepted), 64'(out_addr),
                            64'(beatAddr(v, accepted)));
                checkOutput($sformatf("v%0d out_data b%0d", idx, accepted), 64'(out_data),
                            64'(beatData(v.dataBase, accepted)));
                checkOutput($sformatf("v%0d out_last b%0d", idx, accepted), 64'(out_last),
                            64'(accepted == v.beats - 1));
                fwd++;
            end
            if (WREADY) begin
                accepted++;
            end
            cyc++;
            @(negedge ACLK);
        end
        WVALID    = 1'b0;
        WLAST     = 1'b0;
        out_ready = 1'b1;
        if (accepted < v.beats) begin
            reportTimeout($sformatf("v%0d w_beats", idx));
            return;
        end
        checkOutput($sformatf("v%0d forwarded_count", idx), 64'(fwd), 64'(v.expFwd));

        checkOutput($sformatf("v%0d bvalid", idx), 64'(BVALID), 64'(1'b1));
        checkOutput($sformatf("v%0d bresp", idx), 64'(BRESP), 64'(v.expResp));
        respSeen = BRESP;
        BREADY = 1'b0;
        for (int d = 0; d < v.breadyDelay; d++) begin
            @(negedge ACLK);
            checkOutput($sformatf("v%0d bvalid_hold d%0d", idx, d), 64'(BVALID), 64'(1'b1));
            checkOutput($sformatf("v%0d bresp_hold d%0d", idx, d), 64'(BRESP), 64'(respSeen));
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        checkOutput($sformatf("v%0d bvalid_after_hs", idx), 64'(BVALID), 64'(1'b0));
        checkOutput($sformatf("v%0d awready_gap", idx), 64'(AWREADY), 64'(1'b0));
        @(negedge ACLK);
        checkOutput($sformatf("v%0d awready_back", idx), 64'(AWREADY), 64'(1'b1));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //            addr   sz  burst  beats dataBase      bpS bpL brD resp  fwd
        vecs[0]  = '{8'hA0, 3'd2, 2'b01, 1,  32'h1234_5678, 0, 0, 0, 2'b00, 1};
        vecs[1]  = '{8'hA0, 3'd2, 2'b01, 4,  32'h1000_0001, 0, 0, 0, 2'b00, 4};
        vecs[2]  = '{8'hA0, 3'd2, 2'b00, 4,  32'h2000_0002, 0, 0, 0, 2'b00, 4};
        vecs[3]  = '{8'h84, 3'd2, 2'b01, 6,  32'h3000_0003, 2, 5, 0, 2'b00, 6};
        vecs[4]  = '{8'h10, 3'd2, 2'b01, 3,  32'h4000_0004, 0, 3, 0, 2'b11, 0};
        vecs[5]  = '{8'hAA, 3'd3, 2'b01, 2,  32'h5000_0005, 0, 0, 0, 2'b10, 0};
        vecs[6]  = '{8'hA0, 3'd2, 2'b11, 2,  32'h6000_0006, 0, 0, 0, 2'b10, 0};
        vecs[7]  = '{8'hA0, 3'd2, 2'b10, 2,  32'h7000_0007, 0, 0, 0, 2'b10, 0};
        vecs[8]  = '{8'h80, 3'd0, 2'b01, 3,  32'h8000_0008, 0, 0, 0, 2'b00, 3};
        vecs[9]  = '{8'hBF, 3'd1, 2'b01, 2,  32'h9000_0009, 0, 0, 0, 2'b00, 2};
        vecs[10] = '{8'h7F, 3'd2, 2'b01, 1,  32'hA000_000A, 0, 0, 0, 2'b11, 0};
        vecs[11] = '{8'hC0, 3'd2, 2'b01, 1,  32'hB000_000B, 0, 0, 0, 2'b11, 0};
        vecs[12] = '{8'hA0, 3'd2, 2'b01, 20, 32'hC000_000C, 0, 0, 0, 2'b10, 16};
        vecs[13] = '{8'hA4, 3'd2, 2'b01, 2,  32'hD000_000D, 0, 0, 7, 2'b00, 2};

        ARESETn   = 1'b0;
        AWVALID   = 1'b0;
        AWADDR    = 8'h00;
        AWSIZE    = 3'd0;
        AWBURST   = 2'b00;
        WVALID    = 1'b0;
        WDATA     = 32'h0;
        WLAST     = 1'b0;
        BREADY    = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(negedge ACLK);
        #1;
        checkOutput("reset awready", 64'(AWREADY), 64'(1'b0));
        checkOutput("reset bvalid", 64'(BVALID), 64'(1'b0));
        checkOutput("reset bresp", 64'(BRESP), 64'(2'b00));
        checkOutput("reset wready", 64'(WREADY), 64'(1'b0));
        checkOutput("reset out_valid", 64'(out_valid), 64'(1'b0));

        // First cycle out of reset still has AWREADY low.
        ARESETn = 1'b1;
        @(negedge ACLK);
        checkOutput("first idle awready", 64'(AWREADY), 64'(1'b1));

        // Stray W traffic in IDLE must be ignored.
        WVALID = 1'b1;
        WDATA  = 32'hDEAD_BEEF;
        WLAST  = 1'b1;
        #1;
        checkOutput("idle wready", 64'(WREADY), 64'(1'b0));
        checkOutput("idle out_valid", 64'(out_valid), 64'(1'b0));
        @(negedge ACLK);
        WVALID = 1'b0;
        WLAST  = 1'b0;
        checkOutput("idle still idle", 64'(AWREADY), 64'(1'b1));

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset while beat 2 of a 4-beat burst is being presented.
        AWVALID = 1'b1;
        AWADDR  = 8'hA0;
        AWSIZE  = 3'd2;
        AWBURST = 2'b01;
        @(negedge ACLK);
        AWVALID   = 1'b0;
        WVALID    = 1'b1;
        WDATA     = 32'hAAAA_0000;
        WLAST     = 1'b0;
        out_ready = 1'b1;
        #1;
        checkOutput("rst_mid beat1 out_valid", 64'(out_valid), 64'(1'b1));
        checkOutput("rst_mid beat1 out_addr", 64'(out_addr), 64'(8'hA0));
        @(negedge ACLK);
        WDATA   = 32'hAAAA_0001;
        ARESETn = 1'b0;
        @(negedge ACLK);
        #1;
        checkOutput("rst_mid wready", 64'(WREADY), 64'(1'b0));
        checkOutput("rst_mid out_valid", 64'(out_valid), 64'(1'b0));
        checkOutput("rst_mid bvalid", 64'(BVALID), 64'(1'b0));
        checkOutput("rst_mid awready", 64'(AWREADY), 64'(1'b0));
        ARESETn = 1'b1;
        WVALID  = 1'b0;
        @(negedge ACLK);
        #1;
        checkOutput("rst_mid out_valid after", 64'(out_valid), 64'(1'b0));
        checkOutput("rst_mid bvalid after", 64'(BVALID), 64'(1'b0));
        checkOutput("rst_mid awready after", 64'(AWREADY), 64'(1'b1));
        @(negedge ACLK);

        // A fresh burst after the abandoned one completes normally.
        applyStimulus(vecs[1], 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
